// File: rtl/user_out_arbiter_if.sv
// user_out_arbiter_if: requester-side and leaf-side stream signals of the output arbiter.
interface user_out_arbiter_if #(
    parameter int NUM_REQ      = 4,
    parameter int PAYLOAD_BITS = 32,
    parameter int SRC_BITS     = 2
);
    logic [NUM_REQ*PAYLOAD_BITS-1:0] req_din;
    logic [NUM_REQ-1:0]              req_vld;
    logic [NUM_REQ-1:0]              req_ack;
    logic [PAYLOAD_BITS-1:0]         dout;
    logic [SRC_BITS-1:0]             dout_src;
    logic                            vld_out;
    logic                            ack_in;
    logic                            busy;
    logic [15:0]                     xfer_count;
    modport master (
        input  req_din, req_vld, ack_in,
        output req_ack, dout, dout_src, vld_out, busy, xfer_count
    );
    modport slave (
        output req_din, req_vld, ack_in,
        input  req_ack, dout, dout_src, vld_out, busy, xfer_count
    );
endinterface

// File: rtl/user_out_arbiter.sv
// user_out_arbiter: merges NUM_REQ user streams onto one registered leaf port,
// round-robin with a per-owner burst limit.
module user_out_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int PAYLOAD_BITS = 32,
    parameter int SRC_BITS     = 2,
    parameter int MAX_BURST    = 4
) (
    input logic                clk_user,
    input logic                reset,
    user_out_arbiter_if.master bus
);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);

    logic [NUM_REQ-1:0][PAYLOAD_BITS-1:0] words;
    logic [PAYLOAD_BITS-1:0]              dout;
    logic [SRC_BITS-1:0]                  dout_src;
    logic [SRC_BITS-1:0]                  last_grant;
    logic [SRC_BITS-1:0]                  grant;
    logic [BW-1:0]                        burst_cnt;
    logic [15:0]                          xfer_count;
    logic                                 vld_out;
    logic                                 load_en;
    logic                                 any_vld;
    logic                                 owner_ok;
    logic                                 take;

    function automatic logic [SRC_BITS-1:0] rr_pick(input logic [NUM_REQ-1:0] vld,
                                                    input logic [SRC_BITS-1:0] last);
        logic [SRC_BITS-1:0] pick;
        logic [SRC_BITS-1:0] k;
        pick = last;
        for (int i = NUM_REQ; i >= 1; i--) begin
            k = SRC_BITS'((int'(last) + i) % NUM_REQ);
            if (vld[k]) pick = k;
        end
        return pick;
    endfunction

    assign words    = bus.req_din;
    assign any_vld  = |bus.req_vld;
    assign load_en  = !vld_out || bus.ack_in;
    // A zero burst count means nobody owns the port, so the search starts after last_grant.
    assign owner_ok = burst_cnt != '0 && burst_cnt < BURST_MAX && bus.req_vld[last_grant];
    assign grant    = owner_ok ? last_grant : rr_pick(bus.req_vld, last_grant);
    assign take     = reset && load_en && any_vld;

    assign bus.req_ack    = take ? NUM_REQ'(1) << grant : '0;
    assign bus.dout       = dout;
    assign bus.dout_src   = dout_src;
    assign bus.vld_out    = vld_out;
    assign bus.busy       = vld_out || any_vld;
    assign bus.xfer_count = xfer_count;

    always_ff @(posedge clk_user or negedge reset) begin
        if (!reset) begin
            dout       <= '0;
            dout_src   <= '0;
            vld_out    <= 1'b0;
            last_grant <= SRC_BITS'(NUM_REQ - 1);
            burst_cnt  <= '0;
            xfer_count <= '0;
        end else begin
            if (take) begin
                dout       <= words[grant];
                dout_src   <= grant;
                vld_out    <= 1'b1;
                last_grant <= grant;
                burst_cnt  <= (grant == last_grant && burst_cnt < BURST_MAX) ? burst_cnt + 1'b1 : BW'(1);
            end else if (load_en) begin
                vld_out <= 1'b0;
            end
            if (!any_vld) burst_cnt <= '0;
            if (vld_out && bus.ack_in) xfer_count <= xfer_count + 16'd1;
        end
    end
endmodule

// File: tb/tb_user_out_arbiter.sv
// tb_user_out_arbiter: two arbiters (MAX_BURST 4 and 1) driven by directed steps;
// acked words go into per-instance scoreboards and are matched against the leaf output.
module tb_user_out_arbiter;
    localparam int N = 4;
    localparam int P = 32;
    localparam int S = 2;
    localparam int W = S + P;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    user_out_arbiter_if #(.NUM_REQ(N), .PAYLOAD_BITS(P), .SRC_BITS(S)) b0 ();
    user_out_arbiter_if #(.NUM_REQ(N), .PAYLOAD_BITS(P), .SRC_BITS(S)) b1 ();

    user_out_arbiter #(.NUM_REQ(N), .PAYLOAD_BITS(P), .SRC_BITS(S), .MAX_BURST(4)) dut0 (
        .clk_user(clk), .reset(reset_n), .bus(b0.master));
    user_out_arbiter #(.NUM_REQ(N), .PAYLOAD_BITS(P), .SRC_BITS(S), .MAX_BURST(1)) dut1 (
        .clk_user(clk), .reset(reset_n), .bus(b1.master));

    int          checks = 0;
    int          errors = 0;
    int          rem [2][N];
    logic [15:0] seq [2][N];
    logic        ackin [2];
    logic [15:0] xc [2];
    int          acked [2];
    logic [W-1:0] sb [2][$];
    int          gexp [2][$];

    logic [N-1:0] o_ack [2];
    logic [P-1:0] o_dout [2];
    logic [S-1:0] o_src [2];
    logic         o_vo [2];
    logic         o_busy [2];
    logic [15:0]  o_cnt [2];

    assign b0.ack_in = ackin[0];
    assign b1.ack_in = ackin[1];
    assign o_ack[0] = b0.req_ack;    assign o_ack[1] = b1.req_ack;
    assign o_dout[0] = b0.dout;      assign o_dout[1] = b1.dout;
    assign o_src[0] = b0.dout_src;   assign o_src[1] = b1.dout_src;
    assign o_vo[0] = b0.vld_out;     assign o_vo[1] = b1.vld_out;
    assign o_busy[0] = b0.busy;      assign o_busy[1] = b1.busy;
    assign o_cnt[0] = b0.xfer_count; assign o_cnt[1] = b1.xfer_count;

    for (genvar i = 0; i < N; i++) begin : g_req
        assign b0.req_din[i*P +: P] = {16'hA5A5 ^ 16'(i << 8), seq[0][i]};
        assign b1.req_din[i*P +: P] = {16'hA5A5 ^ 16'(i << 8), seq[1][i]};
        assign b0.req_vld[i] = rem[0][i] != 0;
        assign b1.req_vld[i] = rem[1][i] != 0;
    end

    function automatic logic [W-1:0] word(int k, int i);
        return {S'(i), 16'hA5A5 ^ 16'(i << 8), seq[k][i]};
    endfunction

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sample();
        for (int k = 0; k < 2; k++) begin
            acked[k] = -1;
            if (o_vo[k] && ackin[k]) begin
                xc[k]++;
                if (sb[k].size() == 0) check($sformatf("sb_underflow%0d", k), 64'(sb[k].size()), 64'd1);
                else check($sformatf("out%0d", k), 64'({o_src[k], o_dout[k]}), 64'(sb[k].pop_front()));
            end
            if (o_ack[k] != '0) begin
                for (int i = 0; i < N; i++) if (o_ack[k][i]) acked[k] = i;
                check($sformatf("ack_onehot%0d", k), 64'($countones(o_ack[k])), 64'd1);
                check($sformatf("ack_valid%0d", k), 64'(rem[k][acked[k]] != 0), 64'd1);
                if (gexp[k].size() != 0) check($sformatf("grant%0d", k), 64'(acked[k]), 64'(gexp[k].pop_front()));
                sb[k].push_back(word(k, acked[k]));
            end
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            if (acked[k] >= 0) begin
                seq[k][acked[k]]++;
                rem[k][acked[k]]--;
            end
        end
    endtask

    task automatic cyc(int n);
        repeat (n) begin
            @(negedge clk);
            sample();
            advance();
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            ackin[k] = 1'b1;
            xc[k] = '0;
            acked[k] = -1;
            for (int i = 0; i < N; i++) begin
                rem[k][i] = 0;
                seq[k][i] = 16'd1;
            end
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("rst_vld_out", 64'(o_vo[k]), 64'd0);
            check("rst_dout", 64'(o_dout[k]), 64'd0);
            check("rst_src", 64'(o_src[k]), 64'd0);
            check("rst_ack", 64'(o_ack[k]), 64'd0);
            check("rst_cnt", 64'(o_cnt[k]), 64'd0);
            check("rst_busy", 64'(o_busy[k]), 64'd0);
        end
        for (int i = 0; i < N; i++) rem[0][i] = 1;
        #1;
        check("rst_ack_gated", 64'(o_ack[0]), 64'd0);
        check("rst_busy_req", 64'(o_busy[0]), 64'd1);
        for (int i = 0; i < N; i++) rem[0][i] = 0;
        @(posedge clk);
        #1 reset_n = 1'b1;

        // Burst limit on dut0 alongside plain round robin on dut1.
        rem[0][0] = 12;
        rem[0][2] = 12;
        for (int j = 0; j < 24; j++) gexp[0].push_back(((j / 4) % 2) * 2);
        for (int i = 0; i < N; i++) rem[1][i] = 2;
        for (int j = 0; j < 8; j++) gexp[1].push_back(j % 4);
        @(negedge clk);
        check("first_grant", 64'(o_ack[0]), 64'b0001);
        sample();
        advance();
        cyc(30);
        check("rr_count", 64'(o_cnt[1]), 64'd8);
        check("burst_count", 64'(o_cnt[0]), 64'd24);
        check("grants_done0", 64'(gexp[0].size()), 64'd0);
        check("grants_done1", 64'(gexp[1].size()), 64'd0);

        // Lone requester keeps the grant past MAX_BURST; then backpressure.
        rem[0][1] = 10;
        for (int j = 0; j < 10; j++) gexp[0].push_back(1);
        cyc(2);
        ackin[0] = 1'b0;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            check("stall_ack", 64'(o_ack[0]), 64'd0);
            check("stall_vo", 64'(o_vo[0]), 64'd1);
            check("stall_hold", 64'({o_src[0], o_dout[0]}), 64'(sb[0].size() != 0 ? sb[0][0] : '1));
            sample();
            advance();
        end
        ackin[0] = 1'b1;
        cyc(14);
        check("bp_count", 64'(o_cnt[0]), 64'd34);
        check("bp_drained", 64'(sb[0].size()), 64'd0);
        @(negedge clk);
        check("idle_busy", 64'(o_busy[0]), 64'd0);
        check("idle_vo", 64'(o_vo[0]), 64'd0);
        sample();
        advance();

        // Transfer counter wrap on dut1.
        for (int i = 0; i < N; i++) rem[1][i] = 20000;
        for (int n = 0; n < 70000 && xc[1] != 16'hFFFF; n++) cyc(1);
        check("cnt_ffff", 64'(o_cnt[1]), 64'hFFFF);
        cyc(1);
        check("cnt_wrap", 64'(o_cnt[1]), 64'd0);

        // Asynchronous reset in the middle of traffic.
        rem[0][0] = 50;
        rem[0][3] = 50;
        cyc(3);
        #2 reset_n = 1'b0;
        #1;
        check("async_vo0", 64'(o_vo[0]), 64'd0);
        check("async_vo1", 64'(o_vo[1]), 64'd0);
        check("async_dout1", 64'(o_dout[1]), 64'd0);
        check("async_cnt1", 64'(o_cnt[1]), 64'd0);
        check("async_ack1", 64'(o_ack[1]), 64'd0);
        for (int k = 0; k < 2; k++) begin
            sb[k].delete();
            gexp[k].delete();
            xc[k] = '0;
            acked[k] = -1;
            for (int i = 0; i < N; i++) rem[k][i] = 0;
        end
        rem[0][1] = 1;
        rem[0][3] = 1;
        gexp[0].push_back(1);
        gexp[0].push_back(3);
        seq[1][0] = 16'd1;
        rem[1][0] = 1;
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check("post_rst_grant", 64'(o_ack[0]), 64'b0010);
        check("single_ack", 64'(o_ack[1]), 64'b0001);
        sample();
        advance();
        @(negedge clk);
        check("single_dout", 64'(o_dout[1]), 64'hA5A5_0001);
        check("single_src", 64'(o_src[1]), 64'd0);
        check("single_vo", 64'(o_vo[1]), 64'd1);
        sample();
        advance();
        @(negedge clk);
        check("single_vo_fall", 64'(o_vo[1]), 64'd0);
        check("single_cnt", 64'(o_cnt[1]), 64'd1);
        sample();
        advance();
        cyc(3);
        check("end_sb0", 64'(sb[0].size()), 64'd0);
        check("end_sb1", 64'(sb[1].size()), 64'd0);
        check("end_grants0", 64'(gexp[0].size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
